// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_if
// Brief    : Control bundle between the multi-cycle controller and the
//            datapath (opcode/zero in, ALU controls and strobes out).
// Revision : 1.0  initial release
// ============================================================================
interface multi_cycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       pcwre;
    logic       irwre;
    logic       alusrca;
    logic       alusrcb;
    logic [2:0] aluop;
    logic       extsel;
    logic       regdst;
    logic       regwre;
    logic       dbdatasrc;
    logic       mrd;
    logic       mwr;
    logic [1:0] pcsrc;

    // Controller side: consumes opcode/zero, issues everything else.
    modport master (
        input  opcode, zero,
        output state, pcwre, irwre, alusrca, alusrcb, aluop, extsel,
               regdst, regwre, dbdatasrc, mrd, mwr, pcsrc
    );

    // Datapath side.
    modport slave (
        output opcode, zero,
        input  state, pcwre, irwre, alusrca, alusrcb, aluop, extsel,
               regdst, regwre, dbdatasrc, mrd, mwr, pcsrc
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Brief    : Multi-cycle CPU control unit. Steps each instruction through
//            IF/ID/EXE/MEM/WB and drives ALU controls and datapath enables
//            combinationally from the current state and opcode.
// Revision : 1.0  initial release
// ============================================================================
module multi_cycle_ctrl (
    input  wire                 clk,
    input  wire                 rst_n,
    multi_cycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_B  = 3'b101,
        S_EXE_R  = 3'b110,
        S_WB_R   = 3'b111
    } state_t;

    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_ADDIU = 6'b000010;
    localparam logic [5:0] c_OP_AND   = 6'b010000;
    localparam logic [5:0] c_OP_ANDI  = 6'b010001;
    localparam logic [5:0] c_OP_ORI   = 6'b010010;
    localparam logic [5:0] c_OP_OR    = 6'b010011;
    localparam logic [5:0] c_OP_SLL   = 6'b011000;
    localparam logic [5:0] c_OP_SLT   = 6'b100110;
    localparam logic [5:0] c_OP_SLTI  = 6'b100111;
    localparam logic [5:0] c_OP_SW    = 6'b110000;
    localparam logic [5:0] c_OP_LW    = 6'b110001;
    localparam logic [5:0] c_OP_BEQ   = 6'b110100;
    localparam logic [5:0] c_OP_BNE   = 6'b110101;
    localparam logic [5:0] c_OP_J     = 6'b111000;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_SHL = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_AND = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b110;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_halt;
    logic       w_halt_nxt;

    // Per-opcode arithmetic decode (used by EXE_R/WB_R and for ExtSel)
    logic       w_is_arith;
    logic       w_is_rtype;
    logic [2:0] w_aluop_r;
    logic       w_srca_r;
    logic       w_srcb_r;
    logic       w_ext_r;

    logic       w_pcwre, w_irwre, w_alusrca, w_alusrcb, w_extsel;
    logic       w_regdst, w_regwre, w_dbdatasrc, w_mrd, w_mwr;
    logic [2:0] w_aluop;
    logic [1:0] w_pcsrc;

    // State and halt-flag registers; reset returns to IF asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IF;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    // Arithmetic-class opcode decode: ALU op, operand selects, extension
    always_comb begin
        w_is_arith = 1'b1;
        w_is_rtype = 1'b0;
        w_aluop_r  = c_ALU_ADD;
        w_srca_r   = 1'b0;
        w_srcb_r   = 1'b0;
        w_ext_r    = 1'b0;
        case (bus.opcode)
            c_OP_ADD:   w_is_rtype = 1'b1;
            c_OP_SUB:   begin w_is_rtype = 1'b1; w_aluop_r = c_ALU_SUB; end
            c_OP_ADDIU: begin w_srcb_r = 1'b1; w_ext_r = 1'b1; end
            c_OP_AND:   begin w_is_rtype = 1'b1; w_aluop_r = c_ALU_AND; end
            c_OP_ANDI:  begin w_srcb_r = 1'b1; w_aluop_r = c_ALU_AND; end
            c_OP_ORI:   begin w_srcb_r = 1'b1; w_aluop_r = c_ALU_OR; end
            c_OP_OR:    begin w_is_rtype = 1'b1; w_aluop_r = c_ALU_OR; end
            c_OP_SLL:   begin w_is_rtype = 1'b1; w_srca_r = 1'b1; w_aluop_r = c_ALU_SHL; end
            c_OP_SLT:   begin w_is_rtype = 1'b1; w_aluop_r = c_ALU_SLT; end
            c_OP_SLTI:  begin w_srcb_r = 1'b1; w_ext_r = 1'b1; w_aluop_r = c_ALU_SLT; end
            default:    w_is_arith = 1'b0;
        endcase
    end

    // Next-state and output decode; every strobe defaults low
    always_comb begin
        w_state_nxt = r_state;
        w_halt_nxt  = r_halt;
        w_pcwre     = 1'b0;
        w_irwre     = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 1'b0;
        w_aluop     = c_ALU_ADD;
        w_extsel    = 1'b0;
        w_regdst    = 1'b0;
        w_regwre    = 1'b0;
        w_dbdatasrc = 1'b0;
        w_mrd       = 1'b0;
        w_mwr       = 1'b0;
        w_pcsrc     = 2'b00;
        case (r_state)
            S_IF: begin
                w_irwre     = 1'b1;
                w_state_nxt = S_ID;
            end
            S_ID: begin
                // Once halted, the opcode is no longer looked at
                if (!r_halt) begin
                    if (w_is_arith) begin
                        w_state_nxt = S_EXE_R;
                    end else begin
                        case (bus.opcode)
                            c_OP_SW, c_OP_LW:   w_state_nxt = S_EXE_LS;
                            c_OP_BEQ, c_OP_BNE: w_state_nxt = S_EXE_B;
                            c_OP_J: begin
                                w_pcwre     = 1'b1;
                                w_pcsrc     = 2'b10;
                                w_state_nxt = S_IF;
                            end
                            c_OP_HALT: w_halt_nxt = 1'b1;
                            default: begin
                                w_pcwre     = 1'b1;
                                w_state_nxt = S_IF;
                            end
                        endcase
                    end
                end
            end
            S_EXE_R, S_WB_R: begin
                w_aluop   = w_aluop_r;
                w_alusrca = w_srca_r;
                w_alusrcb = w_srcb_r;
                w_extsel  = w_ext_r;
                if (r_state == S_EXE_R) begin
                    w_state_nxt = S_WB_R;
                end else begin
                    w_regwre    = 1'b1;
                    w_regdst    = w_is_rtype;
                    w_pcwre     = 1'b1;
                    w_state_nxt = S_IF;
                end
            end
            S_EXE_LS: begin
                w_alusrcb   = 1'b1;
                w_extsel    = 1'b1;
                w_state_nxt = S_MEM;
            end
            S_MEM: begin
                w_alusrcb = 1'b1;
                w_extsel  = 1'b1;
                if (bus.opcode == c_OP_LW) begin
                    w_mrd       = 1'b1;
                    w_state_nxt = S_WB_L;
                end else begin
                    w_mwr       = 1'b1;
                    w_pcwre     = 1'b1;
                    w_state_nxt = S_IF;
                end
            end
            S_WB_L: begin
                // Address-path ALU controls stay put while the load lands
                w_alusrcb   = 1'b1;
                w_extsel    = 1'b1;
                w_mrd       = 1'b1;
                w_dbdatasrc = 1'b1;
                w_regwre    = 1'b1;
                w_pcwre     = 1'b1;
                w_state_nxt = S_IF;
            end
            S_EXE_B: begin
                w_aluop  = c_ALU_SUB;
                w_extsel = 1'b1;
                w_pcwre  = 1'b1;
                if (((bus.opcode == c_OP_BEQ) &&  bus.zero) ||
                    ((bus.opcode == c_OP_BNE) && !bus.zero))
                    w_pcsrc = 2'b01;
                w_state_nxt = S_IF;
            end
            default: w_state_nxt = S_IF;
        endcase
    end

    assign bus.state     = r_state;
    assign bus.pcwre     = w_pcwre;
    assign bus.irwre     = w_irwre;
    assign bus.alusrca   = w_alusrca;
    assign bus.alusrcb   = w_alusrcb;
    assign bus.aluop     = w_aluop;
    assign bus.extsel    = w_extsel;
    assign bus.regdst    = w_regdst;
    assign bus.regwre    = w_regwre;
    assign bus.dbdatasrc = w_dbdatasrc;
    assign bus.mrd       = w_mrd;
    assign bus.mwr       = w_mwr;
    assign bus.pcsrc     = w_pcsrc;

endmodule
`default_nettype wire
